// File: rtl/rca_pkg.sv
// Shared types and constants for the ripple-carry adder result checker.
package rca_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCapture,
    StCompare,
    StDone
  } state_t;

  // Active-low 7-segment patterns, bit 7 is the decimal point (kept off).
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_P     = 8'h8C;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low 7-segment pattern with the decimal point off.
module seg7_hex_decoder (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hFF;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/rca_result_checker.sv
// Captures adder results after a settle delay, checks them against a golden sum,
// tallies pass/error counts and drives the 7-segment display.
module rca_result_checker
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_TESTS     = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             MAX10_CLK1_50,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             done,
  output logic             pass,
  output logic [7:0]       HEX0,
  output logic [7:0]       HEX1,
  output logic [7:0]       HEX2,
  output logic [7:0]       HEX3,
  output logic [7:0]       HEX4,
  output logic [7:0]       HEX5
);

  localparam logic [7:0]       SettleLoad = 8'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] NumTestsC  = CNT_W'(NUM_TESTS);

  state_t           state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH:0]   cap_q, cap_d;
  logic [WIDTH:0]   golden;
  logic [CNT_W-1:0] test_q, test_d, err_q, err_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic             done_q, done_d, pass_q, pass_d;
  logic [7:0]       hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;
  logic [7:0]       err_disp, test_disp;
  logic [7:0]       seg_err_lo, seg_err_hi, seg_test_lo, seg_test_hi;

  assign golden = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    cap_d    = cap_q;
    test_d   = test_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    done_d   = done_q;
    pass_d   = pass_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = op_a;
          b_d      = op_b;
          cin_d    = cin;
          settle_d = SettleLoad;
          state_d  = StWait;
        end
      end
      StWait: begin
        settle_d = settle_q - 8'd1;
        if (settle_q <= 8'd1) state_d = StCapture;
      end
      StCapture: begin
        cap_d   = {dut_cout, dut_sum};
        state_d = StCompare;
      end
      StCompare: begin
        if (test_q != '1) test_d = test_q + 1'b1;
        if (cap_q != golden) begin
          // Only the first failing vector is kept for display/debug.
          if (err_q == '0) begin
            fail_a_d = a_q;
            fail_b_d = b_q;
          end
          if (err_q != '1) err_d = err_q + 1'b1;
        end
        if (test_d == NumTestsC) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = StIdle;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state_q  <= StIdle;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      cap_q    <= '0;
      test_q   <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      cap_q    <= cap_d;
      test_q   <= test_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign err_disp  = 8'(err_q);
  assign test_disp = 8'(test_q);

  seg7_hex_decoder u_seg_err_lo (.nibble(err_disp[3:0]),  .seg(seg_err_lo));
  seg7_hex_decoder u_seg_err_hi (.nibble(err_disp[7:4]),  .seg(seg_err_hi));
  seg7_hex_decoder u_seg_test_lo(.nibble(test_disp[3:0]), .seg(seg_test_lo));
  seg7_hex_decoder u_seg_test_hi(.nibble(test_disp[7:4]), .seg(seg_test_hi));

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      hex0_q <= SEG_ZERO;
      hex1_q <= SEG_ZERO;
      hex2_q <= SEG_ZERO;
      hex3_q <= SEG_ZERO;
      hex4_q <= SEG_BLANK;
      hex5_q <= SEG_BLANK;
    end else begin
      hex0_q <= seg_err_lo;
      hex1_q <= seg_err_hi;
      hex2_q <= seg_test_lo;
      hex3_q <= seg_test_hi;
      hex4_q <= SEG_BLANK;
      hex5_q <= done_q ? (pass_q ? SEG_P : SEG_F) : SEG_BLANK;
    end
  end

  assign in_ready   = (state_q == StIdle) && !rst;
  assign test_count = test_q;
  assign err_count  = err_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign HEX0       = hex0_q;
  assign HEX1       = hex1_q;
  assign HEX2       = hex2_q;
  assign HEX3       = hex3_q;
  assign HEX4       = hex4_q;
  assign HEX5       = hex5_q;

endmodule

// File: tb/tb_rca_result_checker.sv
// Directed bench for rca_result_checker with WIDTH=8, SETTLE_CYCLES=2, NUM_TESTS=4.
module tb_rca_result_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a, op_b, dut_sum;
  logic       cin, dut_cout;
  logic [7:0] test_count, err_count, fail_a, fail_b;
  logic       done, pass;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int checks = 0;
  int errors = 0;

  rca_result_checker #(
    .WIDTH        (8),
    .SETTLE_CYCLES(2),
    .NUM_TESTS    (4),
    .CNT_W        (8)
  ) dut (
    .MAX10_CLK1_50(clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .cin          (cin),
    .dut_sum      (dut_sum),
    .dut_cout     (dut_cout),
    .test_count   (test_count),
    .err_count    (err_count),
    .fail_a       (fail_a),
    .fail_b       (fail_b),
    .done         (done),
    .pass         (pass),
    .HEX0         (HEX0),
    .HEX1         (HEX1),
    .HEX2         (HEX2),
    .HEX3         (HEX3),
    .HEX4         (HEX4),
    .HEX5         (HEX5)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the counter-update edge.
  task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] sum, input logic co,
                         input int exp_test, input int exp_err, input bit keep);
    op_a = a; op_b = b; cin = ci; dut_sum = sum; dut_cout = co;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check_eq("accept_ready", in_ready, 1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("ready_low", in_ready, 0);
    end
    check_eq("count_not_early", test_count, exp_test - 1);
    @(negedge clk);
    check_eq("test_count", test_count, exp_test);
    check_eq("err_count", err_count, exp_err);
    check_eq("done", done, (exp_test == 4));
    check_eq("ready_after", in_ready, (exp_test != 4));
    if (!keep) in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; dut_sum = '0; dut_cout = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("ready_in_reset", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_test_count", test_count, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_hex0", HEX0, 8'hC0);
    check_eq("rst_hex1", HEX1, 8'hC0);
    check_eq("rst_hex2", HEX2, 8'hC0);
    check_eq("rst_hex3", HEX3, 8'hC0);
    check_eq("rst_hex4", HEX4, 8'hFF);
    check_eq("rst_hex5", HEX5, 8'hFF);

    // in_valid stays high across vectors: one count per accept.
    run_vec(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1, 0, 1);
    run_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 2, 1, 1);
    check_eq("fail_a", fail_a, 8'hFF);
    check_eq("fail_b", fail_b, 8'h01);
    run_vec(8'h3C, 8'hA5, 1'b1, 8'hE2, 1'b0, 3, 1, 1);
    run_vec(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 4, 1, 1);
    check_eq("fail_a_held", fail_a, 8'hFF);
    check_eq("fail_b_held", fail_b, 8'h01);
    check_eq("done_pass", pass, 0);
    @(negedge clk);
    check_eq("hex0_err", HEX0, 8'hF9);
    check_eq("hex1_err", HEX1, 8'hC0);
    check_eq("hex2_test", HEX2, 8'h99);
    check_eq("hex3_test", HEX3, 8'hC0);
    check_eq("hex4_blank", HEX4, 8'hFF);
    check_eq("hex5_fail", HEX5, 8'h8E);
    repeat (10) @(negedge clk);
    check_eq("done_ignore_count", test_count, 4);
    check_eq("done_ignore_ready", in_ready, 0);
    check_eq("done_held", done, 1);

    // Reset mid-WAIT aborts the vector.
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op_a = 8'h11; op_b = 8'h22; cin = 1'b0; dut_sum = 8'h33; dut_cout = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("in_wait_ready", in_ready, 0);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_test_count", test_count, 0);
    check_eq("abort_err_count", err_count, 0);
    check_eq("abort_fail_a", fail_a, 0);
    check_eq("abort_fail_b", fail_b, 0);
    check_eq("abort_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_idle_ready", in_ready, 1);
    repeat (6) @(negedge clk);
    check_eq("abort_not_counted", test_count, 0);

    // Clean run ending in pass.
    run_vec(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1, 0, 0);
    run_vec(8'h3C, 8'hA5, 1'b1, 8'hE2, 1'b0, 2, 0, 0);
    run_vec(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 3, 0, 0);
    run_vec(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 4, 0, 0);
    check_eq("pass_all", pass, 1);
    @(negedge clk);
    check_eq("hex5_pass", HEX5, 8'h8C);
    check_eq("hex0_zero_err", HEX0, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
